mem_bus_arbiter: RTL and testbench

Shares the single byte-wide RAM/IO port between the instruction cache and the load/store buffer. Each granted 1/2/4-byte request is serialised into per-byte bus cycles. Read bytes are assembled into a 32-bit result, and writes to the UART are held off while its buffer is full. Sits between ICache/LSB and the top-level memory pins; also honours the pipeline-wide `rdy` pause and branch-mispredict flush.

---
 rtl/mem_bus_arbiter_pkg.sv | 40 ++++
 rtl/mem_bus_arbiter_if.sv | 40 ++++
 rtl/mem_bus_arbiter_rr_arbiter2.sv | 45 ++++
 rtl/mem_bus_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the byte-wide memory bus arbiter.
//   state_e        : sequencer state (IDLE / READ / WRITE)
//   req_id_e       : requester identity (ICache / load-store buffer)
//   SIZE_*         : ls_size encodings, size_to_bytes() decodes them to a byte count
//   MEM_IO_MASK    : default value of addr[17:16] that selects IO space
//   byte_sel()     : picks byte k of a little-endian word
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IC  = 1'b0,
    REQ_LSB = 1'b1
  } req_id_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] MEM_IO_MASK = 2'b11;
  localparam logic [2:0] IC_BYTES    = 3'd4;

  // Size 3 is illegal and is serviced as a full word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the requester handshakes and the byte-wide memory pins.
//   ic_*            : ICache word-fetch request / response
//   ls_*            : load-store buffer request / response
//   io_buffer_full  : UART TX full flag
//   mem_*           : RAM/IO port (address, read byte, write byte, write strobe)
// Modport slave is the arbiter; modport master is everything around it.
interface mem_arb_if;

  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_done;
  logic [31:0] ic_data;

  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  ic_req, ic_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
           io_buffer_full, mem_din,
    output ic_done, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output ic_req, ic_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
           io_buffer_full, mem_din,
    input  ic_done, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-input round-robin picker.
//   clk, rst     : clock, asynchronous active-low reset
//   en_i         : arbitration allowed this cycle
//   req_ic_i     : ICache request
//   req_ls_i     : load-store buffer request
//   gnt_valid_o  : a grant is taken this cycle
//   gnt_id_o     : which requester wins
// last_grant records the winner of the most recent contested pick, so ties
// alternate between the two requesters; it resets to IC, handing the first
// tie to the LSB.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en_i,
  input  logic    req_ic_i,
  input  logic    req_ls_i,
  output logic    gnt_valid_o,
  output req_id_e gnt_id_o
);

  req_id_e last_grant_q;

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_valid_o = en_i && (req_ic_i || req_ls_i);
    gnt_id_o    = REQ_IC;
    if (req_ic_i && req_ls_i) begin
      gnt_id_o = (last_grant_q == REQ_IC) ? REQ_LSB : REQ_IC;
    end else if (req_ls_i) begin
      gnt_id_o = REQ_LSB;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= REQ_IC;
    end else if (en_i && req_ic_i && req_ls_i) begin
      last_grant_q <= gnt_id_o;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single byte-wide RAM/IO port between ICache and the LSB and
// serialises each granted 1/2/4-byte access into per-byte bus cycles.
//   clk, rst : clock, asynchronous active-low reset
//   rdy      : pipeline pause, all state frozen while low
//   flush    : branch mispredict, aborts any read in flight
//   bus      : requester handshakes and memory pins (mem_arb_if.slave)
// Reads have a two-cycle address-to-capture latency (synchronous RAM), so an
// issue pointer runs ahead of a capture pointer. Writes stall on a full UART
// when the byte address falls in IO space.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [1:0] IO_MASK = MEM_IO_MASK
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     flush,
  mem_arb_if.slave bus
);

  state_e      state_q;
  req_id_e     id_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [2:0]  n_q;
  logic [2:0]  iss_q;       // next read byte to put on the bus
  logic [2:0]  cap_q;       // next read byte to capture; byte index in WRITE
  logic        issued_q;    // mem_a holds a read address this cycle
  logic        pend_q;      // mem_din carries a requested byte this cycle
  logic        paused_q;    // previous edge was frozen by rdy

  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q;
  logic        ic_done_q;
  logic        ls_done_q;
  logic [31:0] ic_data_q;
  logic [31:0] ls_rdata_q;

  function automatic logic io_blocked(input logic [31:0] a, input logic full);
    return (a[17:16] == IO_MASK) && full;
  endfunction

  // A request still held during its done cycle must not be re-granted, so
  // arbitration waits out any done pulse.
  logic    grant_en;
  logic    gnt_valid;
  req_id_e gnt_id;

  assign grant_en = rdy && !flush && (state_q == ST_IDLE) && !ic_done_q && !ls_done_q;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .en_i        (grant_en),
    .req_ic_i    (bus.ic_req),
    .req_ls_i    (bus.ls_req),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  logic [31:0] g_addr_d;
  logic [2:0]  g_n_d;
  logic        g_we_d;

  always_comb begin
    g_addr_d = bus.ic_addr;
    g_n_d    = IC_BYTES;
    g_we_d   = 1'b0;
    if (gnt_id == REQ_LSB) begin
      g_addr_d = bus.ls_addr;
      g_n_d    = size_to_bytes(bus.ls_size);
      g_we_d   = bus.ls_we;
    end
  end

  // Assembled read word with the byte on mem_din dropped into its lane.
  logic [31:0] data_d;

  always_comb begin
    data_d = data_q;
    data_d[{cap_q[1:0], 3'b000} +: 8] = bus.mem_din;
  end

  // Next write byte: advance only once the current byte actually went out.
  logic [2:0]  wk_d;
  logic [31:0] wr_addr_d;
  logic [7:0]  wr_byte_d;

  always_comb begin
    wk_d      = mem_wr_q ? cap_q + 3'd1 : cap_q;
    wr_addr_d = addr_q + {29'd0, wk_d};
    wr_byte_d = byte_sel(wdata_q, wk_d[1:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      id_q       <= REQ_IC;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      n_q        <= '0;
      iss_q      <= '0;
      cap_q      <= '0;
      issued_q   <= 1'b0;
      pend_q     <= 1'b0;
      paused_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      ic_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      ic_data_q  <= '0;
      ls_rdata_q <= '0;
    end else if (!rdy) begin
      paused_q <= 1'b1;
    end else begin
      paused_q  <= 1'b0;
      ic_done_q <= 1'b0;
      ls_done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            id_q    <= gnt_id;
            addr_q  <= g_addr_d;
            n_q     <= g_n_d;
            wdata_q <= bus.ls_wdata;
            data_q  <= '0;
            cap_q   <= '0;
            mem_a_q <= g_addr_d;
            if (g_we_d) begin
              state_q    <= ST_WRITE;
              mem_dout_q <= bus.ls_wdata[7:0];
              mem_wr_q   <= !io_blocked(g_addr_d, bus.io_buffer_full);
            end else begin
              state_q  <= ST_READ;
              iss_q    <= 3'd1;
              issued_q <= 1'b1;
              pend_q   <= 1'b0;
            end
          end
        end

        ST_READ: begin
          if (flush) begin
            state_q  <= ST_IDLE;
            mem_a_q  <= '0;
            issued_q <= 1'b0;
            pend_q   <= 1'b0;
          end else if (paused_q) begin
            // The RAM kept running during the pause, so anything in flight is
            // stale: restart issue from the first uncaptured byte.
            mem_a_q  <= addr_q + {29'd0, cap_q};
            iss_q    <= cap_q + 3'd1;
            issued_q <= 1'b1;
            pend_q   <= 1'b0;
          end else begin
            pend_q <= issued_q;
            if (iss_q < n_q) begin
              mem_a_q  <= addr_q + {29'd0, iss_q};
              iss_q    <= iss_q + 3'd1;
              issued_q <= 1'b1;
            end else begin
              issued_q <= 1'b0;
            end
            if (pend_q) begin
              data_q <= data_d;
              cap_q  <= cap_q + 3'd1;
              if (cap_q + 3'd1 == n_q) begin
                state_q  <= ST_IDLE;
                mem_a_q  <= '0;
                issued_q <= 1'b0;
                pend_q   <= 1'b0;
                if (id_q == REQ_IC) begin
                  ic_done_q <= 1'b1;
                  ic_data_q <= data_d;
                end else begin
                  ls_done_q  <= 1'b1;
                  ls_rdata_q <= data_d;
                end
              end
            end
          end
        end

        ST_WRITE: begin
          // Stores are committed state: flush never aborts them.
          if (mem_wr_q && (cap_q + 3'd1 == n_q)) begin
            state_q   <= ST_IDLE;
            mem_a_q   <= '0;
            mem_wr_q  <= 1'b0;
            ls_done_q <= 1'b1;
          end else begin
            cap_q      <= wk_d;
            mem_a_q    <= wr_addr_d;
            mem_dout_q <= wr_byte_d;
            mem_wr_q   <= !io_blocked(wr_addr_d, bus.io_buffer_full);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr   = mem_wr_q && rdy;
  assign bus.ic_done  = ic_done_q;
  assign bus.ic_data  = ic_data_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a synchronous byte RAM model with an IO
// write log, hand-computed cycle counts (negedges after the grant edge until
// the done pulse is seen) and data values.
module tb_mem_bus_arbiter;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic rdy   = 1'b1;
  logic flush = 1'b0;

  mem_arb_if bus ();

  mem_bus_arbiter #(.IO_MASK(2'b11)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] wmem   [0:65535];
  logic       wvalid [0:65535];
  int         io_writes = 0;
  logic [7:0] io_last   = 8'h00;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    case (a)
      16'h0100: return 8'h13;
      16'h0101: return 8'h05;
      16'h0102: return 8'h00;
      16'h0103: return 8'h00;
      16'h0010: return 8'h5A;
      16'h2000: return 8'h34;
      16'h2001: return 8'h92;
      16'hFFFE: return 8'h11;
      16'hFFFF: return 8'h22;
      16'h0000: return 8'h33;
      16'h0001: return 8'h44;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    bus.mem_din <= (wvalid[bus.mem_a[15:0]] === 1'b1) ? wmem[bus.mem_a[15:0]]
                                                       : init_byte(bus.mem_a[15:0]);
    if (bus.mem_wr) begin
      if (bus.mem_a[17:16] == 2'b11) begin
        io_writes <= io_writes + 1;
        io_last   <= bus.mem_dout;
      end else begin
        wmem[bus.mem_a[15:0]]   <= bus.mem_dout;
        wvalid[bus.mem_a[15:0]] <= 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " mem_a"},    bus.mem_a,    32'h0);
    check({tag, " mem_dout"}, {24'h0, bus.mem_dout}, 32'h0);
    check({tag, " mem_wr"},   {31'h0, bus.mem_wr},   32'h0);
    check({tag, " ic_done"},  {31'h0, bus.ic_done},  32'h0);
    check({tag, " ls_done"},  {31'h0, bus.ls_done},  32'h0);
    check({tag, " ic_data"},  bus.ic_data,  32'h0);
    check({tag, " ls_rdata"}, bus.ls_rdata, 32'h0);
  endtask

  logic [31:0] a_trace [0:15];

  // Called at a negedge just after a request was raised; returns the number of
  // negedges until the selected done is seen (99 on timeout).
  task automatic wait_done(input logic is_ls, output int cyc);
    cyc = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i <= 16) a_trace[i-1] = bus.mem_a;
      if (is_ls ? bus.ls_done : bus.ic_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_ic(input logic [31:0] addr, output int cyc);
    bus.ic_addr = addr;
    bus.ic_req  = 1'b1;
    wait_done(1'b0, cyc);
    bus.ic_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_ls(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, output int cyc);
    bus.ls_we    = we;
    bus.ls_size  = size;
    bus.ls_addr  = addr;
    bus.ls_wdata = wd;
    bus.ls_req   = 1'b1;
    wait_done(1'b1, cyc);
    bus.ls_req = 1'b0;
    @(negedge clk);
  endtask

  // IC word fetch from 0x100 and LSB byte load from 0x10 raised together.
  task automatic run_tie(output int ic_cyc, output int ls_cyc);
    bus.ic_addr = 32'h0000_0100;
    bus.ls_we   = 1'b0;
    bus.ls_size = 2'd0;
    bus.ls_addr = 32'h0000_0010;
    bus.ic_req  = 1'b1;
    bus.ls_req  = 1'b1;
    ic_cyc = 99;
    ls_cyc = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.ic_done) begin ic_cyc = i; bus.ic_req = 1'b0; end
      if (bus.ls_done) begin ls_cyc = i; bus.ls_req = 1'b0; end
      if (!bus.ic_req && !bus.ls_req) break;
    end
    bus.ic_req = 1'b0;
    bus.ls_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   ic_cyc;
    int   ls_cyc;
    int   io0;
    logic seen;
    logic wr_trace [0:7];

    bus.ic_req         = 1'b0;
    bus.ic_addr        = '0;
    bus.ls_req         = 1'b0;
    bus.ls_we          = 1'b0;
    bus.ls_size        = '0;
    bus.ls_addr        = '0;
    bus.ls_wdata       = '0;
    bus.io_buffer_full = 1'b0;

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // ---- IC word read from 0x100 ----
    run_ic(32'h0000_0100, cyc);
    check("ic read cycles", cyc, 6);
    check("ic read a0", a_trace[0], 32'h0000_0100);
    check("ic read a1", a_trace[1], 32'h0000_0101);
    check("ic read a2", a_trace[2], 32'h0000_0102);
    check("ic read a3", a_trace[3], 32'h0000_0103);
    check("ic read data", bus.ic_data, 32'h0000_0513);

    // ---- first tie: LSB wins, IC right after ----
    run_tie(ic_cyc, ls_cyc);
    check("tie1 ls cycles", ls_cyc, 3);
    check("tie1 ic cycles", ic_cyc, 10);
    check("tie1 ls data", bus.ls_rdata, 32'h0000_005A);
    check("tie1 ic data", bus.ic_data, 32'h0000_0513);

    // ---- second tie: IC wins ----
    run_tie(ic_cyc, ls_cyc);
    check("tie2 ic cycles", ic_cyc, 6);
    check("tie2 ls cycles", ls_cyc, 10);

    // ---- size 3 treated as word, address wraps past 0xFFFFFFFF ----
    run_ls(1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0, cyc);
    check("wrap cycles", cyc, 6);
    check("wrap a1", a_trace[1], 32'hFFFF_FFFF);
    check("wrap a2", a_trace[2], 32'h0000_0000);
    check("wrap a3", a_trace[3], 32'h0000_0001);
    check("wrap data", bus.ls_rdata, 32'h4433_2211);

    // ---- half load from 0x2000 with rdy low for two cycles ----
    bus.ls_we   = 1'b0;
    bus.ls_size = 2'd1;
    bus.ls_addr = 32'h0000_2000;
    bus.ls_req  = 1'b1;
    cyc  = 99;
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.mem_wr) seen = 1'b1;
      if (bus.ls_done) begin cyc = i; break; end
      if (i == 2) rdy = 1'b0;
      if (i == 4) rdy = 1'b1;
    end
    bus.ls_req = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    check("pause cycles", cyc, 8);
    check("pause data", bus.ls_rdata, 32'h0000_9234);
    check("pause mem_wr", {31'h0, seen}, 32'h0);

    // ---- unstalled IO byte store, RAM half store and read-back ----
    io0 = io_writes;
    run_ls(1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041, cyc);
    check("io store cycles", cyc, 2);
    check("io store count", io_writes - io0, 1);
    check("io store byte", {24'h0, io_last}, 32'h0000_0041);
    run_ls(1'b1, 2'd1, 32'h0000_0500, 32'h1234_BEEF, cyc);
    check("half store cycles", cyc, 3);
    run_ls(1'b0, 2'd1, 32'h0000_0500, 32'h0, cyc);
    check("half readback cycles", cyc, 4);
    check("half readback data", bus.ls_rdata, 32'h0000_BEEF);

    // ---- UART full for three cycles during an IO byte store ----
    io0 = io_writes;
    bus.io_buffer_full = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_size  = 2'd0;
    bus.ls_addr  = 32'h0003_0000;
    bus.ls_wdata = 32'h0000_0041;
    bus.ls_req   = 1'b1;
    cyc = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i <= 8) wr_trace[i-1] = bus.mem_wr;
      if (bus.ls_done) begin cyc = i; break; end
      if (i == 3) bus.io_buffer_full = 1'b0;
    end
    bus.ls_req = 1'b0;
    bus.io_buffer_full = 1'b0;
    @(negedge clk);
    check("stall wr c1", {31'h0, wr_trace[0]}, 32'h0);
    check("stall wr c2", {31'h0, wr_trace[1]}, 32'h0);
    check("stall wr c3", {31'h0, wr_trace[2]}, 32'h0);
    check("stall wr c4", {31'h0, wr_trace[3]}, 32'h1);
    check("stall cycles", cyc, 5);
    check("stall io count", io_writes - io0, 1);
    check("stall io byte", {24'h0, io_last}, 32'h0000_0041);

    // ---- flush during the third byte of an IC read, store waiting ----
    bus.ic_addr = 32'h0000_0200;
    bus.ic_req  = 1'b1;
    cyc  = 99;
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.ic_done) seen = 1'b1;
      if (bus.ls_done) begin cyc = i; break; end
      if (i == 3) begin
        flush        = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_size  = 2'd0;
        bus.ls_addr  = 32'h0000_0040;
        bus.ls_wdata = 32'h0000_00A5;
        bus.ls_req   = 1'b1;
      end
      if (i == 4) begin
        check("flush idle mem_a", bus.mem_a, 32'h0);
        flush      = 1'b0;
        bus.ic_req = 1'b0;
      end
      if (i == 5) begin
        check("flush store mem_a", bus.mem_a, 32'h0000_0040);
        check("flush store mem_wr", {31'h0, bus.mem_wr}, 32'h1);
      end
    end
    bus.ls_req = 1'b0;
    bus.ic_req = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush no ic_done", {31'h0, seen}, 32'h0);
    check("flush store cycles", cyc, 6);
    run_ls(1'b0, 2'd0, 32'h0000_0040, 32'h0, cyc);
    check("flush store readback", bus.ls_rdata, 32'h0000_00A5);

    // ---- word store paused once, then reset mid-write ----
    bus.ls_we    = 1'b1;
    bus.ls_size  = 2'd2;
    bus.ls_addr  = 32'h0000_0300;
    bus.ls_wdata = 32'hDEAD_BEEF;
    bus.ls_req   = 1'b1;
    @(negedge clk);
    check("wstore b0 addr", bus.mem_a, 32'h0000_0300);
    check("wstore b0 data", {24'h0, bus.mem_dout}, 32'h0000_00EF);
    check("wstore b0 wr", {31'h0, bus.mem_wr}, 32'h1);
    rdy = 1'b0;
    @(negedge clk);
    check("wstore paused wr", {31'h0, bus.mem_wr}, 32'h0);
    check("wstore paused addr", bus.mem_a, 32'h0000_0300);
    rdy = 1'b1;
    @(negedge clk);
    check("wstore b1 addr", bus.mem_a, 32'h0000_0301);
    check("wstore b1 data", {24'h0, bus.mem_dout}, 32'h0000_00BE);
    #2;
    rst = 1'b0;
    bus.ls_req = 1'b0;
    #1;
    check_outputs_zero("midwrite reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_ls(1'b0, 2'd0, 32'h0000_0300, 32'h0, cyc);
    check("post reset load cycles", cyc, 3);
    check("post reset byte0", bus.ls_rdata, 32'h0000_00EF);
    run_ls(1'b0, 2'd0, 32'h0000_0301, 32'h0, cyc);
    check("post reset byte1 unwritten", bus.ls_rdata, 32'h0000_005B);

    // ---- last_grant back to IC after reset: LSB wins the tie ----
    run_tie(ic_cyc, ls_cyc);
    check("tie3 ls cycles", ls_cyc, 3);
    check("tie3 ic cycles", ic_cyc, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
